// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Initiator side of the data-memory port. Accepts one RISC-V
//               load/store request (valid/ready) and sequences byte/word
//               memory accesses. Halfwords are split into two byte accesses.
//               Load data is returned zero/sign-extended with a one-cycle
//               response pulse.
// Ports       :
//   clk            - clock, all state on posedge
//   reset_n        - synchronous active-low reset
//   i_req_valid    - request present
//   o_req_ready    - unit idle and able to accept
//   i_req_write    - 1=store, 0=load
//   i_req_funct3   - 000 b, 001 h, 010 w, 100 bu, 101 hu
//   i_req_address  - byte address
//   i_req_wdata    - store data (low bits used for b/h)
//   o_resp_valid   - one-cycle completion pulse
//   o_resp_rdata   - extended load data; 0 for stores/errors
//   o_resp_err     - illegal funct3 or out-of-range access
//   o_address      - memory address
//   o_write_data   - memory write data
//   o_MemRead      - memory read strobe
//   o_MemWrite     - memory write strobe
//   o_byte         - 1=byte access, 0=word access
//   i_read_data    - memory read data (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_address,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic [31:0] o_address,
    output logic [31:0] o_write_data,
    output logic        o_MemRead,
    output logic        o_MemWrite,
    output logic        o_byte,
    input  logic [31:0] i_read_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC0 = 2'd1,
        S_ACC1 = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_write;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [7:0]  r_wdata_hi;   // store byte 1, only needed for halfwords
    logic [7:0]  r_b0;         // load byte 0, held across ACC1 for halfwords

    logic [2:0]  w_size;
    logic        w_f3_bad;
    logic [32:0] w_last;
    logic        w_range_bad;
    logic        w_req_word;
    logic [7:0]  w_b0;
    logic [7:0]  w_b1;
    logic [31:0] w_ext;

    assign o_req_ready = (r_state == S_IDLE) & reset_n;

    // Access size in bytes from the incoming request
    always_comb begin
        w_size = 3'd1;
        case (i_req_funct3[1:0])
            2'b00:   w_size = 3'd1;
            2'b01:   w_size = 3'd2;
            2'b10:   w_size = 3'd4;
            default: w_size = 3'd1;
        endcase
    end

    assign w_req_word = (i_req_funct3[1:0] == 2'b10);

    // Stores allow b/h/w only; loads reject 011, 110, 111
    assign w_f3_bad = i_req_write ? (i_req_funct3[2] | (i_req_funct3[1:0] == 2'b11))
                                  : ((i_req_funct3 == 3'b011) | (i_req_funct3[2:1] == 2'b11));

    // 33-bit sum so an address near 2^32 cannot wrap past the check
    assign w_last      = {1'b0, i_req_address} + {30'd0, w_size} - 33'd1;
    assign w_range_bad = (w_last >= 33'(MEM_BYTES));

    // The final access completes in the same cycle the response is formed,
    // so its byte is taken straight from the memory bus.
    assign w_b0 = (r_state == S_ACC0) ? i_read_data[7:0] : r_b0;
    assign w_b1 = i_read_data[7:0];

    always_comb begin
        w_ext = 32'd0;
        if (!r_write) begin
            case (r_funct3)
                3'b000:  w_ext = {{24{w_b0[7]}}, w_b0};
                3'b100:  w_ext = {24'd0, w_b0};
                3'b001:  w_ext = {{16{w_b1[7]}}, w_b1, w_b0};
                3'b101:  w_ext = {16'd0, w_b1, w_b0};
                3'b010:  w_ext = i_read_data;
                default: w_ext = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_write      <= 1'b0;
            r_funct3     <= 3'd0;
            r_addr       <= 32'd0;
            r_wdata_hi   <= 8'd0;
            r_b0         <= 8'd0;
            o_resp_valid <= 1'b0;
            o_resp_rdata <= 32'd0;
            o_resp_err   <= 1'b0;
            o_address    <= 32'd0;
            o_write_data <= 32'd0;
            o_MemRead    <= 1'b0;
            o_MemWrite   <= 1'b0;
            o_byte       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    o_resp_valid <= 1'b0;
                    if (i_req_valid) begin
                        r_write    <= i_req_write;
                        r_funct3   <= i_req_funct3;
                        r_addr     <= i_req_address;
                        r_wdata_hi <= i_req_wdata[15:8];
                        if (w_f3_bad | w_range_bad) begin
                            r_state      <= S_RESP;
                            o_resp_valid <= 1'b1;
                            o_resp_err   <= 1'b1;
                            o_resp_rdata <= 32'd0;
                        end else begin
                            r_state      <= S_ACC0;
                            o_address    <= i_req_address;
                            o_byte       <= ~w_req_word;
                            o_MemRead    <= ~i_req_write;
                            o_MemWrite   <= i_req_write;
                            o_write_data <= w_req_word ? i_req_wdata
                                                       : {24'd0, i_req_wdata[7:0]};
                        end
                    end
                end
                S_ACC0: begin
                    r_b0 <= i_read_data[7:0];
                    if (r_funct3[1:0] == 2'b01) begin
                        r_state      <= S_ACC1;
                        o_address    <= r_addr + 32'd1;
                        o_write_data <= {24'd0, r_wdata_hi};
                    end else begin
                        r_state      <= S_RESP;
                        o_MemRead    <= 1'b0;
                        o_MemWrite   <= 1'b0;
                        o_resp_valid <= 1'b1;
                        o_resp_err   <= 1'b0;
                        o_resp_rdata <= w_ext;
                    end
                end
                S_ACC1: begin
                    r_state      <= S_RESP;
                    o_MemRead    <= 1'b0;
                    o_MemWrite   <= 1'b0;
                    o_resp_valid <= 1'b1;
                    o_resp_err   <= 1'b0;
                    o_resp_rdata <= w_ext;
                end
                S_RESP: begin
                    r_state      <= S_IDLE;
                    o_resp_valid <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
